// File: rtl/fetch_unit.sv
// fetch_unit: PC generator feeding an in-order fetch queue toward decode.
// Define FETCH_MISALIGN_TRAP_EN to halt fetch on misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        misaligned
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  typedef enum logic {
    FETCH,
    HALT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  entry_t        queue [QUEUE_DEPTH];
  logic          push;
  logic          pop;
  logic          mis_redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign mis_redirect = redirect_valid & (|redirect_pc[1:0]);
`else
  assign mis_redirect = 1'b0;
`endif

  assign pc              = fetch_pc;
  assign out_valid       = (count != '0);
  assign out_instruction = queue[rd_ptr].insn;
  assign out_pc          = queue[rd_ptr].pc;

  // Next state and push/pop qualification; redirect wins over both.
  always_comb begin
    state_d = state_q;
    pop     = out_valid & out_ready;
    push    = 1'b0;
    if (redirect_valid) begin
      state_d = mis_redirect ? HALT : FETCH;
    end else begin
      case (state_q)
        FETCH:   push = (count < DEPTH_C) | pop;
        HALT:    push = 1'b0;
        default: push = 1'b0;
      endcase
    end
  end

  // State, fetch address, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      fetch_pc <= RESET_PC & ALIGN_MASK;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN_MASK;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          wr_ptr   <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; contents are only observed behind count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      queue[wr_ptr] <= '{pc: fetch_pc, insn: instruction};
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;

  // Sticky until reset or the next aligned redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (redirect_valid) begin
      mis_q <= mis_redirect;
    end
  end

  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, meaning fetch-queue entries; legal values are 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port pc, output, 32, the fetch address driven to the instruction memory.
REQ-006 SHALL have port instruction, input, 32, the word returned combinationally by the instruction memory for pc in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1, a branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32, the redirect target, sampled when redirect_valid=1.
REQ-009 SHALL have port out_valid, output, 1, meaning the queue head is valid toward decode.
REQ-010 SHALL have port out_ready, input, 1, meaning decode accepts the head.
REQ-011 SHALL have port out_instruction, output, 32, the instruction at the queue head.
REQ-012 SHALL have port out_pc, output, 32, the address of out_instruction.
REQ-013 SHALL have port misaligned, output, 1, a sticky misaligned-redirect flag.

Function
REQ-014 SHALL hold fetch_pc in a register and drive pc = fetch_pc, with pc[1:0] always 2'b00.
REQ-015 SHALL treat a cycle as a push when there is no redirect, the state is FETCH, and (count < QUEUE_DEPTH or a pop occurs in that cycle); a push enqueues {fetch_pc, instruction} and advances fetch_pc by 4.
REQ-016 SHALL add 4 to fetch_pc modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-017 SHALL treat a cycle as a pop when out_valid and out_ready are both 1; a pop removes the head in FIFO order.
REQ-018 SHALL drive out_valid = (count != 0), with out_instruction and out_pc taken from the head entry, and SHALL NOT drive them combinationally from instruction.
REQ-019 SHALL have a latency of exactly one cycle from a push to that entry becoming visible at the head when the queue was empty.
REQ-020 SHALL allow a push and a pop in the same cycle when the queue is full, leaving count unchanged.
REQ-021 SHALL leave count, fetch_pc and the queue unchanged when the queue is full and no pop occurs.
REQ-022 SHALL, when redirect_valid=1, set count to 0, flush all entries, load fetch_pc from redirect_pc with its low two bits cleared, and suppress the push; redirect takes priority over push and pop.
REQ-023 SHALL consider a head offered with out_ready=1 in a redirect cycle as consumed by decode, while still flushing the queue internally.
REQ-024 SHALL implement the state machine FETCH -> HALT on a misaligned redirect (macro on only) and HALT -> FETCH on an aligned redirect; HALT performs no pushes.
REQ-025 SHALL produce the first out_valid=1 one cycle after the first cycle with rst=0, with out_pc = RESET_PC.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set fetch_pc=RESET_PC, count=0, read/write pointers=0, state=FETCH, out_valid=0 and misaligned=0.
REQ-027 SHALL give rst priority over redirect, push and pop, and SHALL discard all in-flight entries when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, when FETCH_MISALIGN_TRAP_EN is defined, enter HALT on a redirect with redirect_pc[1:0]!=0 and set misaligned=1 until reset or an aligned redirect.
REQ-029 SHALL, when FETCH_MISALIGN_TRAP_EN is undefined, silently clear the low redirect bits, never enter HALT, and tie misaligned to 0.

Verification
REQ-030 SHALL be covered by a reset scenario: RESET_PC=0 with out_ready=1 held -> out_pc sequence 0,4,8,... on consecutive cycles with out_valid=1 from the second cycle.
REQ-031 SHALL be covered by a backpressure scenario: out_ready=0 for 5 cycles with depth 2 -> pc stalls at 8 with two entries (0,4) held; releasing ready -> heads 0,4,8 in order with no loss or duplication.
REQ-032 SHALL be covered by a redirect scenario: redirect_pc=0x100 while the queue is full -> next cycle out_valid=0, pc=0x100; the cycle after that out_pc=0x100.
REQ-033 SHALL be covered by a misalign scenario: redirect_pc=0x102 -> with the macro, misaligned=1, pc=0x100 and no pushes, and a redirect to 0x200 clears the flag; without the macro, fetching continues from 0x100.
REQ-034 SHALL be covered by a wrap scenario: redirect to 0xFFFF_FFFC -> out_pc sequence 0xFFFF_FFFC, 0x0.
REQ-035 SHALL be covered by a mid-reset scenario: rst pulsed with 2 entries queued -> next cycle out_valid=0 and pc=RESET_PC.
